seq_mult_ctrl: RTL and testbench
================================

Name: seq_mult_ctrl

Overview:
Multi-cycle 32x32 -> 64-bit multiplier sequencer for the ALU's MUL path.
- Accepts one operand pair per START, runs a radix-2 shift-add loop on the shared 32-bit ripple adder, and applies sign correction with 64-bit two's complement.
- Returns HI/LO to the control unit with a one-cycle DONE pulse.
- Replaces the combinational multiplier so the processor stalls on BUSY instead of lengthening the cycle.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- ITER, 32, shift-add iterations; must equal WIDTH.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only in IDLE.
- SIGNED  input  1  1 = signed (two's complement) multiply; 0 = unsigned.
- A  input  32  multiplicand, sampled with START.
- B  input  32  multiplier, sampled with START.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse, result valid.
- HI  output  32  product[63:32].
- LO  output  32  product[31:0].

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE; BUSY=0, DONE=0, HI=0, LO=0; counter=0; internal operands cleared.
- States: IDLE, SETUP, ITER, FIX, DONE.
- IDLE:
  - START=1 at an edge latches A, B and SIGNED, and moves to SETUP.
  - START=0 stays in IDLE.
- SETUP (1 cycle):
  - mcand = |A| and mplier = |B| when SIGNED=1 and the operand MSB is 1 (32-bit two's complement); otherwise raw values.
  - neg = SIGNED & (A[31]^B[31]).
  - Clears the 64-bit accumulator {P_hi,P_lo}, loads P_lo=mplier, sets count=0, then moves to ITER.
- ITER (32 cycles, one per edge):
  - If P_lo[0]=1, sum = P_hi + mcand (33-bit with carry); otherwise sum = P_hi.
  - {P_hi,P_lo} <= {carry, sum, P_lo[31:1]} (logical right shift carrying the adder carry-out in).
  - count increments; when count==31, move to FIX.
- FIX (1 cycle): product = neg ? two's complement of {P_hi,P_lo} : {P_hi,P_lo}. HI/LO are loaded; move to DONE.
- DONE (1 cycle): DONE=1, BUSY=1, then IDLE.
- Latency: 35 edges from the START-sampling edge to the DONE state; DONE is high during cycle 35.
- HI/LO hold their value until the next FIX. They are never cleared by START.
- START while BUSY is ignored and not queued. START high in the DONE cycle is also ignored; the requester re-asserts in IDLE.
- Corner cases:
  - Signed 0x80000000 * 0x80000000: |A| = 0x80000000 (unsigned magnitude), result 0x4000000000000000.
  - Zero operand with neg=1: negating 0 yields 0, so no -0 exists.
- RESET asserted mid-operation aborts immediately to IDLE with all outputs zero. No partial result is visible.
- SIGNED, A and B changing after the sampling edge have no effect.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined:
  - In ITER, when the unshifted remaining multiplier bits are all zero (mplier >> count == 0), the accumulator is shifted right by the remaining (32 - count) positions in one cycle and the state moves to FIX.
  - Minimum latency is 4 edges: B=0 gives SETUP, one ITER cycle, FIX, DONE.
  - Results are bit-identical to the non-early path.
- Not defined: fixed 35-edge latency; no early-termination logic is synthesized.

Decomposition:
- Shared definitions file:
  - State encodings: IDLE=3'd0, SETUP=3'd1, ITER=3'd2, FIX=3'd3, DONE=3'd4.
  - WIDTH and ITER defaults.
  - Product width constant 64.
- Sub-module: seq_mult_dp. It holds the operand registers, the accumulator, the 32-bit adder instance, and the two's-complement (32 and 64-bit) instances.
- seq_mult_ctrl keeps only the FSM, the counter, and the load/shift/negate enables.

Test Plan:
- Unsigned: SIGNED=0, A=0x0000FFFF, B=0x00010001 -> DONE at edge 35, HI=0x00000000, LO=0xFFFFFFFF (0x0000FFFF*0x00010001 = 0xFFFFFFFF).
- Signed negative: SIGNED=1, A=0xFFFFFFFD (-3), B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB (-21).
- Signed extreme: SIGNED=1, A=B=0x80000000 -> HI=0x40000000, LO=0x00000000. Also unsigned A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- Handshake: START re-pulsed at edges 5 and 35 with different operands -> ignored; first result unchanged; BUSY high from edge 1 through the DONE cycle; exactly one DONE pulse.
- Reset mid-op: RESET low at edge 12 -> BUSY=0, DONE=0, HI=LO=0 immediately; after release, START with A=2, B=3 -> LO=6, HI=0.
- With SEQ_MULT_EARLY_TERM_EN: A=0x12345678, B=0 -> DONE within 4 edges, product 0. B=0x00000003 -> result 0x369D0368 (LO), HI=0, in under 35 edges.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM encoding, default sizes.
package seq_mult_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITER_DEF  = 32;
    localparam int PROD_W    = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ITER  = 3'd2,
        ST_FIX   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/seq_mult_dp.sv
// Multiplier datapath: operand latches, shift-add accumulator, sign magnitude and product negation.
// Optional SEQ_MULT_EARLY_TERM_EN adds the zero-remainder detect and bulk accumulator shift.
module seq_mult_dp
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             setup_en,
    input  logic             iter_en,
    input  logic             fix_en,
`ifdef SEQ_MULT_EARLY_TERM_EN
    input  logic             early_en,
    input  logic [$clog2(WIDTH)-1:0] count,
    input  logic [$clog2(WIDTH):0]   shift_amt,
    output logic             rem_zero,
`endif
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int PW = 2 * WIDTH;

    logic [WIDTH-1:0] a_r, b_r, mcand, p_hi, p_lo;
    logic             sgn_r, neg_r;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    acc, prod;

    assign a_mag = (sgn_r && a_r[WIDTH-1]) ? (~a_r + WIDTH'(1)) : a_r;
    assign b_mag = (sgn_r && b_r[WIDTH-1]) ? (~b_r + WIDTH'(1)) : b_r;
    assign sum   = p_lo[0] ? ({1'b0, p_hi} + {1'b0, mcand}) : {1'b0, p_hi};
    assign acc   = {p_hi, p_lo};
    assign prod  = neg_r ? (~acc + PW'(1)) : acc;

`ifdef SEQ_MULT_EARLY_TERM_EN
    // b_r is stable for the whole operation, so the magnitude can be recomputed here.
    assign rem_zero = ((b_mag >> count) == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            sgn_r <= 1'b0;
            mcand <= '0;
            neg_r <= 1'b0;
            p_hi  <= '0;
            p_lo  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (load_en) begin
                a_r   <= a;
                b_r   <= b;
                sgn_r <= sgn;
            end
            if (setup_en) begin
                mcand <= a_mag;
                neg_r <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                p_hi  <= '0;
                p_lo  <= b_mag;
            end
            if (iter_en) begin
`ifdef SEQ_MULT_EARLY_TERM_EN
                if (early_en)
                    {p_hi, p_lo} <= acc >> shift_amt;
                else
`endif
                    {p_hi, p_lo} <= {sum, p_lo[WIDTH-1:1]};
            end
            if (fix_en) begin
                hi <= prod[PW-1:WIDTH];
                lo <= prod[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequencer for the 32x32->64 shift-add multiplier: FSM, iteration counter, datapath enables.
// Optional SEQ_MULT_EARLY_TERM_EN ends the loop once the remaining multiplier bits are zero.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int ITER  = ITER_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam int CNT_W = $clog2(ITER);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             load_en, setup_en, iter_en, fix_en;

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic             rem_zero, early_en;
    logic [CNT_W:0]   shift_amt;

    assign early_en  = iter_en & rem_zero;
    assign shift_amt = (CNT_W + 1)'(ITER) - {1'b0, count};
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)        count <= '0;
        else if (setup_en) count <= '0;
        else if (iter_en)  count <= count + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        setup_en  = 1'b0;
        iter_en   = 1'b0;
        fix_en    = 1'b0;
        BUSY      = 1'b1;
        DONE      = 1'b0;
        case (state)
            ST_IDLE: begin
                BUSY    = 1'b0;
                load_en = START;
                if (START) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                setup_en  = 1'b1;
                state_nxt = ST_ITER;
            end
            ST_ITER: begin
                iter_en = 1'b1;
`ifdef SEQ_MULT_EARLY_TERM_EN
                if (rem_zero) state_nxt = ST_FIX;
`endif
                if (count == CNT_W'(ITER - 1)) state_nxt = ST_FIX;
            end
            ST_FIX: begin
                fix_en    = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                DONE      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    seq_mult_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (CLK),
        .rst_n     (RESET),
        .load_en   (load_en),
        .setup_en  (setup_en),
        .iter_en   (iter_en),
        .fix_en    (fix_en),
`ifdef SEQ_MULT_EARLY_TERM_EN
        .early_en  (early_en),
        .count     (count),
        .shift_amt (shift_amt),
        .rem_zero  (rem_zero),
`endif
        .sgn       (SIGNED),
        .a         (A),
        .b         (B),
        .hi        (HI),
        .lo        (LO)
    );

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: directed vectors, monitor pops expectations on DONE.
module tb_seq_mult_ctrl;
    import seq_mult_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic        SIGNED = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic        BUSY, DONE;
    logic [31:0] HI, LO;

    typedef struct {
        logic [PROD_W-1:0] prod;
        int                lat;
        int                start;
        string             name;
    } exp_t;

    exp_t              sb[$];
    int                checks = 0;
    int                errors = 0;
    int                edge_cnt = 0;
    int                done_cnt = 0;
    logic [PROD_W-1:0] last_prod = '0;

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam int LAT_FULL = 0;
`else
    localparam int LAT_FULL = 35;
`endif

    seq_mult_ctrl dut (
        .CLK(CLK), .RESET(RESET), .START(START), .SIGNED(SIGNED),
        .A(A), .B(B), .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && DONE === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got DONE=1 expected no pulse, HI=%h LO=%h", HI, LO);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_product"}, {HI, LO}, e.prod);
                check({e.name, "_busy_in_done"}, 64'(BUSY), 64'd1);
                if (e.lat != 0)
                    check({e.name, "_latency"}, 64'(edge_cnt - e.start + 1), 64'(e.lat));
            end
        end
    end

    task automatic do_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expv, input int lat, input bit repulse,
                         input string name);
        exp_t e;
        int   k;
        int   d0;
        bit   busy_bad;
        d0 = done_cnt;
        @(negedge CLK);
        SIGNED = sgn; A = a; B = b; START = 1'b1;
        @(posedge CLK); #1;
        e.prod = expv; e.lat = lat; e.start = edge_cnt; e.name = name;
        sb.push_back(e);
        @(negedge CLK); #2;
        START = 1'b0; A = ~a; B = a ^ b; SIGNED = ~sgn;
        k = 1;
        busy_bad = 1'b0;
        while (sb.size() != 0 && k < 60) begin
            if (BUSY !== 1'b1) busy_bad = 1'b1;
            if (k == 3) check({name, "_hold_prev"}, {HI, LO}, last_prod);
`ifdef SEQ_MULT_EARLY_TERM_EN
            START = repulse && (k + 1 == 5);
`else
            START = repulse && (k + 1 == 5 || k + 1 == 35);
`endif
            if (START) begin
                A = $urandom; B = $urandom; SIGNED = 1'b1;
            end
            @(negedge CLK); #2;
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no DONE after %0d cycles expected DONE", name, k);
            sb.delete();
        end
        check({name, "_busy_until_done"}, 64'(busy_bad), 64'd0);
        // DONE cycle: a request here must be dropped.
        START = repulse;
        A = 32'hDEAD_BEEF; B = 32'h0000_0005;
        @(negedge CLK); #2;
        START = 1'b0;
        check({name, "_idle_after_done"}, 64'(BUSY), 64'd0);
        @(negedge CLK); #2;
        check({name, "_idle_2"}, 64'(BUSY), 64'd0);
        check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        last_prod = expv;
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        check("reset_state", {31'd0, BUSY, DONE, HI, LO}, 64'd0);
        @(negedge CLK);
        RESET = 1'b1;

        do_op(1'b0, 32'h0000FFFF, 32'h00010001, 64'h00000000_FFFFFFFF, LAT_FULL, 1'b0, "unsigned");
        do_op(1'b1, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB, LAT_FULL, 1'b0, "signed_neg");
        do_op(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, LAT_FULL, 1'b0, "signed_min");
        do_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, LAT_FULL, 1'b0, "unsigned_max");
        do_op(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, LAT_FULL, 1'b0, "signed_m1m1");
        do_op(1'b1, 32'h00000007, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFF2, LAT_FULL, 1'b0, "signed_7m2");
        do_op(1'b1, 32'h00000000, 32'hFFFFFFFF, 64'h00000000_00000000, LAT_FULL, 1'b0, "neg_zero");
        do_op(1'b0, 32'h00001234, 32'h00000010, 64'h00000000_00012340, LAT_FULL, 1'b1, "handshake");

        // Abort mid-operation: outputs must drop to zero as soon as reset asserts.
        do_op(1'b0, 32'h00000009, 32'h00000009, 64'h00000000_00000051, LAT_FULL, 1'b0, "pre_abort");
        @(negedge CLK);
        SIGNED = 1'b0; A = 32'h00011111; B = 32'h00022222; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (10) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("abort_outputs", {31'd0, BUSY, DONE, HI, LO}, 64'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        last_prod = '0;
        do_op(1'b0, 32'h00000002, 32'h00000003, 64'h00000000_00000006, LAT_FULL, 1'b0, "after_abort");

`ifdef SEQ_MULT_EARLY_TERM_EN
        do_op(1'b0, 32'h12345678, 32'h00000000, 64'h00000000_00000000, 4, 1'b0, "early_b0");
        do_op(1'b0, 32'h12345678, 32'h00000003, 64'h00000000_369D0368, 6, 1'b0, "early_b3");
`endif

        repeat (3) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
